// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-fetch detection).
package if_fetch_unit_pkg;

  localparam int  InstAddrBus = 32;
  localparam int  InstBus     = 32;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  // Bit positions inside the 6-bit pipeline stall vector
  localparam int StallPc   = 0;
  localparam int StallIfId = 1;
  localparam int StallId   = 2;

  typedef logic [InstAddrBus-1:0] inst_addr_t;
  typedef logic [InstBus-1:0]     inst_t;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
    logic       adel;
  } ifid_t;

  localparam ifid_t IfIdBubble = '{pc: '0, inst: ZeroWord, adel: 1'b0};

  function automatic inst_addr_t next_seq_pc(input inst_addr_t pc);
    return pc + inst_addr_t'(4);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-side bus: ROM request/response plus the IF/ID register outputs.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic       ce;
  inst_addr_t pc;
  inst_t      inst_i;
  inst_addr_t id_pc;
  inst_t      id_inst;
  logic       id_fetch_adel;

  modport master (
    output ce, pc, id_pc, id_inst, id_fetch_adel,
    input  inst_i
  );

  modport slave (
    input  ce, pc, id_pc, id_inst, id_fetch_adel,
    output inst_i
  );
endinterface

// File: rtl/if_fetch_unit_pc_gen.sv
// Program counter and ROM chip enable with flush/stall/branch next-PC priority.
module if_pc_gen
  import if_fetch_unit_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_pc,
  input  logic       flush,
  input  inst_addr_t new_pc,
  input  logic       branch_flag_i,
  input  inst_addr_t branch_target_address_i,
  output logic       ce,
  output inst_addr_t pc
);

  logic       ce_d, ce_q;
  inst_addr_t pc_d, pc_q;

  always_comb begin
    ce_d = ChipEnable;
    pc_d = pc_q;
    // While disabled the PC parks at RESET_PC; the first fetch uses it unchanged
    if (ce_q == ChipEnable) begin
      if (flush)              pc_d = new_pc;
      else if (stall_pc)      pc_d = pc_q;
      else if (branch_flag_i) pc_d = branch_target_address_i;
      else                    pc_d = next_seq_pc(pc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      ce_q <= ChipDisable;
      pc_q <= RESET_PC;
    end else begin
      ce_q <= ce_d;
      pc_q <= pc_d;
    end
  end

  assign ce = ce_q;
  assign pc = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generator plus the IF/ID pipeline register.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (flags fetches with pc[1:0] != 0).
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  inst_addr_t            new_pc,
  input  logic                  branch_flag_i,
  input  inst_addr_t            branch_target_address_i,
  if_fetch_unit_if.master       bus
);

  logic       ce;
  inst_addr_t pc;
  logic       unused_stall_hi;

  // Later-stage stall bits belong to other stages
  assign unused_stall_hi = ^stall[5:3];

  if_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk                     (clk),
    .rst                     (rst),
    .stall_pc                (stall[StallPc]),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .ce                      (ce),
    .pc                      (pc)
  );

  ifid_t fetched;
  ifid_t ifid_d, ifid_q;

  always_comb begin
    fetched.pc   = pc;
    fetched.inst = (ce == ChipEnable) ? bus.inst_i : ZeroWord;
    fetched.adel = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    // A misaligned fetch becomes a NOP tagged for the exception logic downstream
    if ((ce == ChipEnable) && (pc[1:0] != 2'b00)) begin
      fetched.inst = ZeroWord;
      fetched.adel = 1'b1;
    end
`endif
  end

  always_comb begin
    ifid_d = ifid_q;
    if (flush)
      ifid_d = IfIdBubble;
    else if (stall[StallIfId] && !stall[StallId])
      ifid_d = IfIdBubble;
    else if (!stall[StallIfId])
      ifid_d = fetched;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) ifid_q <= IfIdBubble;
    else                  ifid_q <= ifid_d;
  end

  assign bus.ce      = ce;
  assign bus.pc      = pc;
  assign bus.id_pc   = ifid_q.pc;
  assign bus.id_inst = ifid_q.inst;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.id_fetch_adel = ifid_q.adel;
`else
  assign bus.id_fetch_adel = 1'b0;
`endif

endmodule
